// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key decoder.
//   state_e    : decoder FSM state encoding
//   DOT / DASH : element codes as stored in the pattern register
//   MAX_ELEMS  : elements that fit in the pattern register
//   cnt_width  : register width needed to hold 0..max_val
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int unsigned MAX_ELEMS = 4;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Morse time-unit prescaler.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   restart : zero the prescaler (driven on every synchronised key edge)
//   tick    : one-cycle pulse every UNIT_CYCLES cycles since the last restart
module morse_unit_tick
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned    W    = cnt_width(UNIT_CYCLES - 1);
  localparam logic [W-1:0]   LAST = W'(UNIT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // A restart in the same cycle wins, so a key edge never coincides with a tick.
  assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: classifies key presses into dots/dashes and emits the
// collected symbol once the key has been released for GAP_UNITS units.
//   clk           : system clock
//   rst_n         : synchronous active-low reset
//   key_in        : raw asynchronous key, 1 = pressed
//   pattern       : element code, first element in bit 3 (dot=0, dash=1)
//   length        : element count 0..4
//   pattern_valid : one-cycle pulse qualifying pattern/length/overflow
//   overflow      : more than four elements were keyed in this symbol
//   busy          : decoder is not idle
//
// state | meaning
// IDLE  | waiting for a key press, outputs hold the last symbol
// PRESS | key held, counting units (saturating) to classify the element
// GAP   | key released, counting units until the symbol is complete
// EMIT  | single cycle presenting the finished symbol
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES   = 5000000,
  parameter int unsigned DOT_MAX_UNITS = 2,
  parameter int unsigned GAP_UNITS     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [3:0] pattern,
  output logic [2:0] length,
  output logic       pattern_valid,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (DOT_MAX_UNITS + 1 > GAP_UNITS) ?
                                    (DOT_MAX_UNITS + 1) : GAP_UNITS;
  localparam int unsigned      CNT_W     = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] PRESS_SAT = CNT_W'(DOT_MAX_UNITS + 1);
  localparam logic [CNT_W-1:0] DOT_LIMIT = CNT_W'(DOT_MAX_UNITS);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_UNITS - 1);
  localparam logic [2:0]       LEN_FULL  = 3'(MAX_ELEMS);

  logic key_meta_q, key_s_q, key_prev_q;
  logic key_edge;
  logic tick;

  state_e           state_q;
  logic [CNT_W-1:0] unit_cnt_q;
  logic [3:0]       work_pat_q;
  logic [2:0]       work_len_q;
  logic             ovf_acc_q;

  logic [3:0] pattern_q;
  logic [2:0] length_q;
  logic       pattern_valid_q;
  logic       overflow_q;
  logic       busy_q;

  logic       press_glitch;
  logic       elem_code;
  logic [3:0] elem_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      key_meta_q <= key_in;
      key_s_q    <= key_meta_q;
      key_prev_q <= key_s_q;
    end
  end

  assign key_edge = key_s_q ^ key_prev_q;

  morse_unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_unit_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(key_edge),
    .tick   (tick)
  );

  assign press_glitch = (unit_cnt_q == '0);
  assign elem_code    = (unit_cnt_q > DOT_LIMIT) ? DASH : DOT;
  assign elem_mask    = {elem_code, 3'b000} >> work_len_q[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      unit_cnt_q      <= '0;
      work_pat_q      <= '0;
      work_len_q      <= '0;
      ovf_acc_q       <= 1'b0;
      pattern_q       <= '0;
      length_q        <= '0;
      pattern_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      pattern_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
      case (state_q)
        // Entered on the key level rather than a strict edge so that a press
        // that began during EMIT is picked up here instead of being lost.
        ST_IDLE: begin
          if (key_s_q) begin
            state_q    <= ST_PRESS;
            unit_cnt_q <= '0;
            work_pat_q <= '0;
            work_len_q <= '0;
            ovf_acc_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (!key_s_q) begin
            state_q    <= ST_GAP;
            unit_cnt_q <= '0;
            if (!press_glitch) begin
              if (work_len_q < LEN_FULL) begin
                work_pat_q <= work_pat_q | elem_mask;
                work_len_q <= work_len_q + 3'd1;
              end else begin
                ovf_acc_q <= 1'b1;
              end
            end
          end else if (tick && (unit_cnt_q != PRESS_SAT)) begin
            unit_cnt_q <= unit_cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (key_s_q) begin
            state_q    <= ST_PRESS;
            unit_cnt_q <= '0;
          end else if (tick) begin
            if (unit_cnt_q == GAP_LAST) begin
              state_q         <= ST_EMIT;
              pattern_q       <= work_pat_q;
              length_q        <= work_len_q;
              overflow_q      <= ovf_acc_q;
              pattern_valid_q <= 1'b1;
            end else begin
              unit_cnt_q <= unit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_EMIT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pattern       = pattern_q;
  assign length        = length_q;
  assign pattern_valid = pattern_valid_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

endmodule
